// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default frame parameters,
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int OS_TICK_DEF = 16;
    localparam int SB_TICK_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both stages reset to RESET_VAL so an idle-high line looks idle straight out of reset.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, MSB-first frames, mid-bit sampling.
// Delivers each word with a one-clock done pulse and a framing-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int OS_TICK = OS_TICK_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done_flag,
    output logic            frame_err
);

    localparam int SMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
    localparam int SW   = (SMAX > 2) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 2) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID       = SW'(OS_TICK / 2 - 1);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OS_TICK - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    logic rx_s;

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] d_out_q, d_out_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            d_out_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            d_out_q <= d_out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // All state only moves on s_tick; a low seen at mid-start that has gone
    // high again is treated as a glitch and dropped silently.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        d_out_d = d_out_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (s_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        s_d     = '0;
                    end
                end
                START: begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                DATA: begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = {b_q[DBIT-2:0], rx_s};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                    if (s_q == S_STOP_LAST) begin
                        d_out_d = b_q;
                        done_d  = 1'b1;
                        err_d   = ~rx_s;
                        state_d = IDLE;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign d_out        = d_out_q;
    assign rx_done_flag = done_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: frames are serialised by the bench
// at 16 ticks per bit, with s_tick every 4 clocks.
module tb_uart_rx;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       rx;
    logic [7:0] d_out;
    logic       rx_done_flag;
    logic       frame_err;

    int testCount = 0;
    int failCount = 0;
    int expCount  = 0;

    int         doneCount = 0;
    int         dblCount  = 0;
    logic       prevDone  = 1'b0;
    logic [7:0] logData[$];
    logic       logErr[$];
    logic [1:0] tickCnt;

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .d_out        (d_out),
        .rx_done_flag (rx_done_flag),
        .frame_err    (frame_err)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running baud tick: one clock high out of every TICK_DIV
    initial tickCnt = '0;
    always @(posedge clk) tickCnt <= tickCnt + 2'd1;
    assign s_tick = (tickCnt == 2'(TICK_DIV - 1));

    // Logs every done pulse and flags any pulse lasting more than one clock
    always @(negedge clk) begin
        if (rx_done_flag) begin
            doneCount++;
            logData.push_back(d_out);
            logErr.push_back(frame_err);
            if (prevDone) dblCount++;
        end
        prevDone = rx_done_flag;
    end

    // Watchdog so the bench can never hang
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idleBits(input int nTicks);
        rx = 1'b1;
        repeat (nTicks * TICK_DIV) @(negedge clk);
    endtask

    // Serialises one frame: start, 8 data bits MSB first, stop bit of given level
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            rx = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stopBit;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic waitDone(input int target);
        for (int i = 0; i < 2000 && doneCount < target; i++) @(negedge clk);
    endtask

    task automatic checkFrame(input string tag, input int idx, input logic [7:0] data, input logic err);
        logic [7:0] gotData;
        logic       gotErr;
        gotData = (idx < logData.size()) ? logData[idx] : 8'hxx;
        gotErr  = (idx < logErr.size())  ? logErr[idx]  : 1'bx;
        checkOutput({tag, " data"}, 32'(gotData), 32'(data));
        checkOutput({tag, " err"},  32'(gotErr),  32'(err));
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state
        checkOutput("reset d_out", 32'(d_out), 32'h00);
        checkOutput("reset done",  32'(rx_done_flag), 32'h0);
        checkOutput("reset ferr",  32'(frame_err), 32'h0);
        reset = 1'b1;
        idleBits(8);

        // Nominal frame
        applyStimulus(8'hA5, 1'b1);
        expCount++;
        waitDone(expCount);
        idleBits(4);
        checkOutput("nominal count", 32'(doneCount), 32'(expCount));
        checkFrame("nominal", 0, 8'hA5, 1'b0);
        checkOutput("nominal held d_out", 32'(d_out), 32'hA5);
        checkOutput("nominal pulse width", 32'(dblCount), 32'h0);

        // Start glitch: low for 4 ticks only
        rx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        idleBits(40);
        checkOutput("glitch count", 32'(doneCount), 32'(expCount));
        checkOutput("glitch d_out", 32'(d_out), 32'hA5);

        // Framing error, then a clean frame clears the flag
        applyStimulus(8'h3C, 1'b0);
        expCount++;
        waitDone(expCount);
        idleBits(32);
        checkFrame("ferr", 1, 8'h3C, 1'b1);
        checkOutput("ferr held flag", 32'(frame_err), 32'h1);
        applyStimulus(8'h11, 1'b1);
        expCount++;
        waitDone(expCount);
        idleBits(4);
        checkFrame("after ferr", 2, 8'h11, 1'b0);
        checkOutput("after ferr count", 32'(doneCount), 32'(expCount));

        // Back-to-back frames with no idle gap
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        expCount += 2;
        waitDone(expCount);
        idleBits(4);
        checkOutput("b2b count", 32'(doneCount), 32'(expCount));
        checkFrame("b2b first", 3, 8'h00, 1'b0);
        checkFrame("b2b second", 4, 8'hFF, 1'b0);

        // Reset during data bit 3 of 0x96 (bits so far: 1,0,0, now 1)
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midreset d_out", 32'(d_out), 32'h00);
        checkOutput("midreset done",  32'(rx_done_flag), 32'h0);
        checkOutput("midreset ferr",  32'(frame_err), 32'h0);
        repeat (4) @(negedge clk);
        rx = 1'b1;
        reset = 1'b1;
        idleBits(200);
        checkOutput("midreset no pulse", 32'(doneCount), 32'(expCount));
        applyStimulus(8'h5A, 1'b1);
        expCount++;
        waitDone(expCount);
        idleBits(4);
        checkFrame("post reset", 5, 8'h5A, 1'b0);

        // Frame as the transmitter would send it
        applyStimulus(8'hC3, 1'b1);
        expCount++;
        waitDone(expCount);
        idleBits(4);
        checkFrame("loopback", 6, 8'hC3, 1'b0);
        checkOutput("loopback d_out", 32'(d_out), 32'hC3);

        // Break: line low for 320 ticks gives exactly two 0x00 frames with error
        rx = 1'b0;
        repeat (320 * TICK_DIV) @(negedge clk);
        expCount += 2;
        checkOutput("break count", 32'(doneCount), 32'(expCount));
        checkFrame("break first", 7, 8'h00, 1'b1);
        checkFrame("break second", 8, 8'h00, 1'b1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        reset = 1'b1;
        idleBits(8);

        checkOutput("overall pulse width", 32'(dblCount), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
